// File: rtl/roce_pkg.sv
// Shared definitions for the RoCE TX meta arbiter slice.
// Contents:
//   - bit offsets and widths of the fields inside a RoCE TX meta word
//   - RDMA opcode encodings carried in the meta opcode field
//   - arbiter FSM state type
package roce_pkg;

  // Meta word field layout. The arbiter forwards the word untouched; these
  // constants document the layout for requesters and checkers.
  localparam int OP_LSB    = 0;
  localparam int OP_W      = 3;
  localparam int QPN_LSB   = 3;
  localparam int QPN_W     = 24;
  localparam int LADDR_LSB = 27;
  localparam int LADDR_W   = 48;
  localparam int RADDR_LSB = 75;
  localparam int RADDR_W   = 48;
  localparam int LEN_LSB   = 123;
  localparam int LEN_W     = 32;

  // RDMA opcodes
  localparam logic [2:0] RDMA_WRITE = 3'b001;
  localparam logic [2:0] RDMA_READ  = 3'b000;

  // ARB: looking for an eligible requester; SEND: holding one meta beat
  typedef enum logic [0:0] {
    ARB  = 1'b0,
    SEND = 1'b1
  } arb_state_t;

endpackage

// File: rtl/roce_tag_fifo.sv
// Synchronous FIFO of requester tags, one entry per issued command.
// The arbiter pushes the owning requester index when a meta beat leaves and
// pops it when the matching completion is routed back.
// Ports:
//   clk, rst        clock, synchronous active-high reset (empties the FIFO)
//   push, push_tag  write request and tag; accepted when not full or when a
//                   pop happens in the same cycle
//   pop             read request; ignored when empty
//   head_tag        tag at the head (valid only when empty is 0)
//   full, empty     occupancy flags
module roce_tag_fifo
  import roce_pkg::*;
#(
  parameter int TAG_W = 2,
  parameter int DEPTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [TAG_W-1:0] push_tag,
  input  logic             pop,
  output logic [TAG_W-1:0] head_tag,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [TAG_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_en_s;
  logic             rd_en_s;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == {CNT_W{1'b0}});
  assign head_tag = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; a pop in the same cycle frees the slot
  // a push into a full FIFO needs.
  always_comb begin
    rd_en_s  = pop & ~empty;
    wr_en_s  = push & (~full | rd_en_s);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en_s) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_en_s) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_en_s, rd_en_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Tag storage; contents are only meaningful below the occupancy count
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q] <= push_tag;
    end
  end

endmodule

// File: rtl/roce_tx_meta_arbiter.sv
// Shares one RoCE TX meta stream between NUM_REQ requesters and routes each
// TX status beat back to the requester whose command it completes.
//  - Round-robin grant, one whole meta beat per grant, at most one grant per
//    two cycles (ARB cycle + at least one SEND cycle).
//  - Each requester may have at most MAX_OUTSTANDING commands in flight.
//  - Issued requester indices are queued in a tag FIFO; statuses return in
//    issue order and take their tdest from the FIFO head.
// Ports:
//   ap_clk, areset              clock, synchronous active-high reset
//   s_axis_req_*                per-requester meta input (channel i at i*META_W)
//   m_axis_tx_meta_*            meta towards the RoCE stack (tkeep/tlast constant)
//   s_axis_tx_status_*          completions from the RoCE stack
//   m_axis_status_*             routed completions, tdest = owning requester
//   outstanding                 per-channel in-flight counts, packed
//   err_orphan_status           sticky: a status arrived with nothing in flight
module roce_tx_meta_arbiter
  import roce_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int META_W          = 256,
  parameter int STATUS_W        = 512,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                                               ap_clk,
  input  logic                                               areset,
  input  logic [NUM_REQ-1:0]                                 s_axis_req_tvalid,
  output logic [NUM_REQ-1:0]                                 s_axis_req_tready,
  input  logic [NUM_REQ*META_W-1:0]                          s_axis_req_tdata,
  output logic                                               m_axis_tx_meta_tvalid,
  input  logic                                               m_axis_tx_meta_tready,
  output logic [META_W-1:0]                                  m_axis_tx_meta_tdata,
  output logic [META_W/8-1:0]                                m_axis_tx_meta_tkeep,
  output logic                                               m_axis_tx_meta_tlast,
  input  logic                                               s_axis_tx_status_tvalid,
  output logic                                               s_axis_tx_status_tready,
  input  logic [STATUS_W-1:0]                                s_axis_tx_status_tdata,
  output logic                                               m_axis_status_tvalid,
  input  logic                                               m_axis_status_tready,
  output logic [STATUS_W-1:0]                                m_axis_status_tdata,
  output logic [$clog2(NUM_REQ)-1:0]                         m_axis_status_tdest,
  output logic [NUM_REQ*($clog2(MAX_OUTSTANDING)+1)-1:0]     outstanding,
  output logic                                               err_orphan_status
);

  localparam int TAG_W      = $clog2(NUM_REQ);
  localparam int TAG_W1     = TAG_W + 1;
  localparam int CNT_W      = $clog2(MAX_OUTSTANDING) + 1;
  localparam int FIFO_DEPTH = NUM_REQ * MAX_OUTSTANDING;

  arb_state_t        state_q, state_d;
  logic              meta_tvalid_q, meta_tvalid_d;
  logic [META_W-1:0] meta_tdata_q, meta_tdata_d;
  logic [TAG_W-1:0]  grant_q, grant_d;
  logic [TAG_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  cnt_q [NUM_REQ];
  logic [CNT_W-1:0]  cnt_d [NUM_REQ];
  logic              err_orphan_q, err_orphan_d;

  logic [NUM_REQ-1:0] eligible_s;
  logic               grant_found_s;
  logic [TAG_W-1:0]   grant_idx_s;
  logic [TAG_W1-1:0]  cand_s;
  logic [META_W-1:0]  grant_tdata_s;
  logic [NUM_REQ-1:0] cnt_inc_s;
  logic [NUM_REQ-1:0] cnt_dec_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic [TAG_W-1:0]   fifo_head_s;
  logic               meta_push_s;
  logic               status_pop_s;

  // Requester eligibility: wants to send, has credit, and a tag slot exists
  always_comb begin
    eligible_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible_s[i] = s_axis_req_tvalid[i] & (cnt_q[i] < CNT_W'(MAX_OUTSTANDING)) & ~fifo_full_s;
    end
  end

  // Round-robin pick: first eligible channel at or after rr_ptr_q, wrapping.
  // cand_s is one bit wider so rr_ptr + k can exceed NUM_REQ before the wrap.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    cand_s        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s = {1'b0, rr_ptr_q} + TAG_W1'(k);
      if (cand_s >= TAG_W1'(NUM_REQ)) begin
        cand_s = cand_s - TAG_W1'(NUM_REQ);
      end else begin
        cand_s = cand_s;
      end
      if (!grant_found_s && eligible_s[cand_s[TAG_W-1:0]]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = cand_s[TAG_W-1:0];
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Select the granted requester's meta word
  always_comb begin
    grant_tdata_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx_s == TAG_W'(i)) begin
        grant_tdata_s = s_axis_req_tdata[i*META_W +: META_W];
      end else begin
        grant_tdata_s = grant_tdata_s;
      end
    end
  end

  // The input handshake happens in the ARB cycle itself; the beat is captured
  // into the output register on the same edge.
  always_comb begin
    s_axis_req_tready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      s_axis_req_tready[i] = (state_q == ARB) & grant_found_s & (grant_idx_s == TAG_W'(i));
    end
  end

  // FSM next state and output register next values
  always_comb begin
    state_d       = state_q;
    meta_tvalid_d = meta_tvalid_q;
    meta_tdata_d  = meta_tdata_q;
    grant_d       = grant_q;
    rr_ptr_d      = rr_ptr_q;
    case (state_q)
      ARB: begin
        if (grant_found_s) begin
          meta_tdata_d  = grant_tdata_s;
          grant_d       = grant_idx_s;
          meta_tvalid_d = 1'b1;
          state_d       = SEND;
        end else begin
          meta_tvalid_d = 1'b0;
        end
      end
      SEND: begin
        if (m_axis_tx_meta_tready) begin
          meta_tvalid_d = 1'b0;
          rr_ptr_d      = (grant_q == TAG_W'(NUM_REQ - 1)) ? '0 : grant_q + TAG_W'(1);
          state_d       = ARB;
        end else begin
          meta_tvalid_d = 1'b1;
        end
      end
      default: begin
        meta_tvalid_d = 1'b0;
        state_d       = ARB;
      end
    endcase
  end

  // FSM and meta output register
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      state_q       <= ARB;
      meta_tvalid_q <= 1'b0;
      meta_tdata_q  <= '0;
      grant_q       <= '0;
      rr_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      meta_tvalid_q <= meta_tvalid_d;
      meta_tdata_q  <= meta_tdata_d;
      grant_q       <= grant_d;
      rr_ptr_q      <= rr_ptr_d;
    end
  end

  assign meta_push_s  = (state_q == SEND) & m_axis_tx_meta_tready;
  assign status_pop_s = s_axis_tx_status_tvalid & m_axis_status_tready & ~fifo_empty_s;

  // Credit counters: issue increments, routed completion decrements; both on
  // the same channel in one cycle cancel out.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_inc_s[i] = meta_push_s & (grant_q == TAG_W'(i));
      cnt_dec_s[i] = status_pop_s & (fifo_head_s == TAG_W'(i));
      case ({cnt_inc_s[i], cnt_dec_s[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + CNT_W'(1);
        2'b01:   cnt_d[i] = cnt_q[i] - CNT_W'(1);
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
  end

  // An accepted status with nothing in flight is dropped and flagged
  always_comb begin
    err_orphan_d = err_orphan_q | (s_axis_tx_status_tvalid & fifo_empty_s);
  end

  // Credit counters and orphan flag
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= '0;
      end
      err_orphan_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      err_orphan_q <= err_orphan_d;
    end
  end

  roce_tag_fifo #(
    .TAG_W (TAG_W),
    .DEPTH (FIFO_DEPTH)
  ) u_tag_fifo (
    .clk      (ap_clk),
    .rst      (areset),
    .push     (meta_push_s),
    .push_tag (grant_q),
    .pop      (status_pop_s),
    .head_tag (fifo_head_s),
    .full     (fifo_full_s),
    .empty    (fifo_empty_s)
  );

  // Pack per-channel counts onto the flat outstanding port
  always_comb begin
    outstanding = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      outstanding[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end

  assign m_axis_tx_meta_tvalid = meta_tvalid_q;
  assign m_axis_tx_meta_tdata  = meta_tdata_q;
  assign m_axis_tx_meta_tkeep  = {(META_W/8){1'b1}};
  assign m_axis_tx_meta_tlast  = 1'b1;

  // With nothing in flight the status is swallowed regardless of the
  // downstream ready, so an orphan can never stall the RoCE stack.
  assign s_axis_tx_status_tready = fifo_empty_s | m_axis_status_tready;
  assign m_axis_status_tvalid    = s_axis_tx_status_tvalid & ~fifo_empty_s;
  assign m_axis_status_tdata     = s_axis_tx_status_tdata;
  assign m_axis_status_tdest     = fifo_head_s;
  assign err_orphan_status       = err_orphan_q;

endmodule

// File: tb/tb_roce_tx_meta_arbiter.sv
// Self-checking bench for roce_tx_meta_arbiter: directed scenarios plus a
// randomized run, all checked every cycle against a queue-based model.
module tb_roce_tx_meta_arbiter;
  import roce_pkg::*;

  localparam int NUM_REQ  = 4;
  localparam int META_W   = 256;
  localparam int STATUS_W = 512;
  localparam int MAX_OUT  = 8;
  localparam int TAG_W    = 2;
  localparam int CW       = 4;

  logic                        ap_clk = 1'b0;
  logic                        areset;
  logic [NUM_REQ-1:0]          req_tvalid;
  logic [NUM_REQ-1:0]          req_tready;
  logic [NUM_REQ*META_W-1:0]   req_tdata;
  logic                        tx_tvalid;
  logic                        tx_tready;
  logic [META_W-1:0]           tx_tdata;
  logic [META_W/8-1:0]         tx_tkeep;
  logic                        tx_tlast;
  logic                        st_in_tvalid;
  logic                        st_in_tready;
  logic [STATUS_W-1:0]         st_in_tdata;
  logic                        st_out_tvalid;
  logic                        st_out_tready;
  logic [STATUS_W-1:0]         st_out_tdata;
  logic [TAG_W-1:0]            st_out_tdest;
  logic [NUM_REQ*CW-1:0]       outstanding;
  logic                        err_orphan;

  roce_tx_meta_arbiter #(
    .NUM_REQ(NUM_REQ), .META_W(META_W), .STATUS_W(STATUS_W), .MAX_OUTSTANDING(MAX_OUT)
  ) dut (
    .ap_clk                  (ap_clk),
    .areset                  (areset),
    .s_axis_req_tvalid       (req_tvalid),
    .s_axis_req_tready       (req_tready),
    .s_axis_req_tdata        (req_tdata),
    .m_axis_tx_meta_tvalid   (tx_tvalid),
    .m_axis_tx_meta_tready   (tx_tready),
    .m_axis_tx_meta_tdata    (tx_tdata),
    .m_axis_tx_meta_tkeep    (tx_tkeep),
    .m_axis_tx_meta_tlast    (tx_tlast),
    .s_axis_tx_status_tvalid (st_in_tvalid),
    .s_axis_tx_status_tready (st_in_tready),
    .s_axis_tx_status_tdata  (st_in_tdata),
    .m_axis_status_tvalid    (st_out_tvalid),
    .m_axis_status_tready    (st_out_tready),
    .m_axis_status_tdata     (st_out_tdata),
    .m_axis_status_tdest     (st_out_tdest),
    .outstanding             (outstanding),
    .err_orphan_status       (err_orphan)
  );

  always #5 ap_clk = ~ap_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic tb_check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: in-flight tags in issue order, per-channel credits,
  // round-robin pointer and the one pending meta beat.
  int                m_rr;
  int                m_cnt [NUM_REQ];
  int                m_tagq [$];
  bit                m_pending;
  int                m_grant;
  logic [META_W-1:0] m_meta;
  bit                m_orphan;
  int                grant_log [$];
  int                dest_log [$];
  int                rdy_pulses;
  int                out_beats;

  logic [NUM_REQ-1:0] req_hs_seen = '0;
  bit                 st_hs_seen  = 1'b0;

  // Stimulus controls
  logic [NUM_REQ-1:0] want;
  int                 st_send_n;
  bit                 st_auto;
  int                 tx_pct;
  int                 st_pct;

  task automatic model_reset();
    m_rr = 0;
    for (int i = 0; i < NUM_REQ; i++) m_cnt[i] = 0;
    m_tagq.delete();
    m_pending = 1'b0;
    m_grant   = 0;
    m_meta    = '0;
    m_orphan  = 1'b0;
  endtask

  task automatic monitor_cycle();
    logic [NUM_REQ-1:0] exp_rdy;
    int  g;
    int  c;
    bit  q_empty;
    bit  exp_st_rdy;
    req_hs_seen = req_tvalid & req_tready;
    st_hs_seen  = st_in_tvalid & st_in_tready;
    if (areset) begin
      model_reset();
    end else begin
      if (req_tready != '0) rdy_pulses++;
      if (st_out_tvalid && st_out_tready) out_beats++;
      tb_check("tx_tvalid", tx_tvalid, m_pending);
      if (m_pending) tb_check("tx_tdata", tx_tdata, m_meta);
      for (int i = 0; i < NUM_REQ; i++) tb_check("outstanding", outstanding[i*CW +: CW], m_cnt[i]);
      tb_check("err_orphan", err_orphan, m_orphan);
      exp_rdy = '0;
      g = -1;
      if (!m_pending && m_tagq.size() < NUM_REQ * MAX_OUT) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          c = (m_rr + k) % NUM_REQ;
          if (g < 0 && req_tvalid[c] && m_cnt[c] < MAX_OUT) g = c;
        end
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
      tb_check("req_tready", req_tready, exp_rdy);
      q_empty    = (m_tagq.size() == 0);
      exp_st_rdy = q_empty | st_out_tready;
      tb_check("st_in_tready", st_in_tready, exp_st_rdy);
      tb_check("st_out_tvalid", st_out_tvalid, st_in_tvalid & !q_empty);
      if (st_in_tvalid && !q_empty) begin
        tb_check("st_tdest", st_out_tdest, m_tagq[0]);
        tb_check("st_tdata", st_out_tdata, st_in_tdata);
      end
      // Completion first: a status arriving with the queue empty is an
      // orphan even if a push lands on the same edge.
      if (st_in_tvalid && exp_st_rdy) begin
        if (q_empty) begin
          m_orphan = 1'b1;
        end else begin
          c = m_tagq.pop_front();
          m_cnt[c]--;
          dest_log.push_back(c);
        end
      end
      if (m_pending) begin
        if (tx_tready) begin
          m_tagq.push_back(m_grant);
          m_cnt[m_grant]++;
          m_rr = (m_grant + 1) % NUM_REQ;
          m_pending = 1'b0;
          grant_log.push_back(m_grant);
        end
      end else if (g >= 0) begin
        m_pending = 1'b1;
        m_grant   = g;
        m_meta    = req_tdata[g*META_W +: META_W];
      end
    end
  endtask

  always @(negedge ap_clk) monitor_cycle();

  function automatic logic [META_W-1:0] rand_meta(input int ch);
    logic [META_W-1:0] m;
    for (int w = 0; w < META_W / 32; w++) m[w*32 +: 32] = $urandom;
    m[OP_LSB +: OP_W]       = ($urandom_range(0, 1) == 1) ? RDMA_WRITE : RDMA_READ;
    m[QPN_LSB +: QPN_W]     = QPN_W'(ch + 16);
    m[LADDR_LSB +: LADDR_W] = {16'h0000, $urandom};
    m[RADDR_LSB +: RADDR_W] = {16'h0001, $urandom};
    m[LEN_LSB +: LEN_W]     = LEN_W'($urandom_range(1, 4096));
    return m;
  endfunction

  // One clock: inputs change 1 time unit after the rising edge
  task automatic step();
    @(posedge ap_clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_tvalid[i] && !req_hs_seen[i]) begin
        req_tvalid[i] = 1'b1;
      end else if (want[i]) begin
        req_tvalid[i] = 1'b1;
        req_tdata[i*META_W +: META_W] = rand_meta(i);
      end else begin
        req_tvalid[i] = 1'b0;
      end
    end
    if (st_in_tvalid && !st_hs_seen) begin
      st_in_tvalid = 1'b1;
    end else if (st_send_n > 0 || (st_auto && m_tagq.size() > 0 && $urandom_range(0, 1) == 1)) begin
      if (st_send_n > 0) st_send_n--;
      st_in_tvalid = 1'b1;
      for (int w = 0; w < STATUS_W / 32; w++) st_in_tdata[w*32 +: 32] = $urandom;
    end else begin
      st_in_tvalid = 1'b0;
    end
    tx_tready     = ($urandom_range(0, 99) < tx_pct);
    st_out_tready = ($urandom_range(0, 99) < st_pct);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    want = '0;
    st_send_n = 0;
    st_auto = 1'b0;
    areset = 1'b1;
    steps(2);
    areset = 1'b0;
    grant_log.delete();
    dest_log.delete();
    step();
  endtask

  // Pulse requester ch once (valid held until accepted)
  task automatic issue_one(input int ch);
    want[ch] = 1'b1;
    step();
    want[ch] = 1'b0;
  endtask

  function automatic int count_ch(input int ch);
    int n = 0;
    foreach (grant_log[j]) if (grant_log[j] == ch) n++;
    return n;
  endfunction

  initial begin
    logic [META_W/8-1:0] ones_keep;
    int p0;
    int b0;
    ones_keep = '1;
    areset = 1'b1;
    req_tvalid = '0;
    req_tdata = '0;
    tx_tready = 1'b0;
    st_in_tvalid = 1'b0;
    st_in_tdata = '0;
    st_out_tready = 1'b0;
    want = '0;
    st_send_n = 0;
    st_auto = 1'b0;
    tx_pct = 100;
    st_pct = 100;
    rdy_pulses = 0;
    out_beats = 0;
    steps(3);
    areset = 1'b0;
    step();

    // Reset state
    tb_check("rst_tx_tvalid", tx_tvalid, 1'b0);
    tb_check("rst_outstanding", outstanding, 16'h0000);
    tb_check("rst_err_orphan", err_orphan, 1'b0);
    tb_check("rst_req_tready", req_tready, 4'h0);
    tb_check("tkeep", tx_tkeep, ones_keep);
    tb_check("tlast", tx_tlast, 1'b1);

    // 1: all channels busy, sink always ready -> 0,1,2,3,0,...
    do_reset();
    want = 4'hF;
    steps(40);
    tb_check("t1_grant_count_ge8", grant_log.size() >= 8, 1'b1);
    for (int j = 0; j < 8 && j < grant_log.size(); j++) tb_check("t1_grant_order", grant_log[j], j % 4);

    // 2: credit limit on ch1, then one completion frees a slot
    do_reset();
    want = 4'b0010;
    steps(40);
    tb_check("t2_issued_8", count_ch(1), 8);
    tb_check("t2_out1_8", outstanding[1*CW +: CW], 4'd8);
    st_send_n = 1;
    steps(10);
    tb_check("t2_dest_count", dest_log.size(), 1);
    if (dest_log.size() > 0) tb_check("t2_tdest", dest_log[0], 1);
    tb_check("t2_issued_9", count_ch(1), 9);

    // 3: issue 2,0,3 then complete in order
    do_reset();
    issue_one(2); steps(5);
    issue_one(0); steps(5);
    issue_one(3); steps(5);
    st_send_n = 3;
    steps(15);
    tb_check("t3_dest_count", dest_log.size(), 3);
    for (int j = 0; j < 3 && j < dest_log.size(); j++) tb_check("t3_tdest", dest_log[j], (j == 0) ? 2 : ((j == 1) ? 0 : 3));
    tb_check("t3_out_zero", outstanding, 16'h0000);

    // 4: sink stalls 20 cycles in SEND
    do_reset();
    tx_pct = 0;
    want = 4'hF;
    steps(2);
    p0 = rdy_pulses;
    steps(20);
    tb_check("t4_no_extra_pulse", rdy_pulses, p0);
    tb_check("t4_tvalid_held", tx_tvalid, 1'b1);
    tb_check("t4_no_issue", grant_log.size(), 0);
    tx_pct = 100;
    want = '0;
    steps(10);
    tb_check("t4_issued_after", grant_log.size() >= 1, 1'b1);

    // 5: orphan status
    do_reset();
    b0 = out_beats;
    st_pct = 0;
    st_send_n = 1;
    steps(4);
    tb_check("t5_orphan_set", err_orphan, 1'b1);
    tb_check("t5_no_beat", out_beats, b0);
    steps(10);
    tb_check("t5_orphan_sticky", err_orphan, 1'b1);
    st_pct = 100;
    do_reset();
    tb_check("t5_orphan_cleared", err_orphan, 1'b0);

    // 6: same-cycle issue and completion on ch0, then reset mid-SEND
    do_reset();
    issue_one(0); steps(5);
    tb_check("t6_out0_1", outstanding[CW-1:0], 4'd1);
    tx_pct = 0;
    issue_one(0); steps(3);
    tx_pct = 100;
    st_send_n = 1;
    step();
    step();
    tb_check("t6_out0_same_cycle", outstanding[CW-1:0], 4'd1);
    tb_check("t6_dest", dest_log.size() > 0 ? dest_log[dest_log.size()-1] : -1, 0);
    tx_pct = 0;
    st_pct = 0;
    issue_one(0); steps(2);
    tb_check("t6_in_send", tx_tvalid, 1'b1);
    areset = 1'b1;
    step();
    areset = 1'b0;
    tb_check("t6_rst_tvalid", tx_tvalid, 1'b0);
    tb_check("t6_rst_counts", outstanding, 16'h0000);
    tb_check("t6_rst_fifo_empty", st_in_tready, 1'b1);
    st_send_n = 1;
    steps(4);
    tb_check("t6_orphan_after_rst", err_orphan, 1'b1);
    tx_pct = 100;
    st_pct = 100;

    // 7: randomized traffic with backpressure on both sides
    do_reset();
    tx_pct = 70;
    st_pct = 70;
    st_auto = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      want = NUM_REQ'($urandom);
      step();
    end
    want = '0;
    steps(400);
    tb_check("t7_drained", outstanding, 16'h0000);
    tb_check("t7_traffic", grant_log.size() > 100, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
